// File: rtl/pattern_display.sv
`default_nettype none
// ============================================================================
// Module   : pattern_display
// Purpose  : Generates a random key sequence and flashes it box by box on the
//            160x120 plotter, then hands the sequence to the input stage.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_display #(
   parameter int         ON_CYCLES    = 25_000_000,
   parameter int         OFF_CYCLES   = 12_500_000,
   parameter logic [7:0] LFSR_SEED    = 8'hA5,
   parameter logic [2:0] FLASH_COLOUR = 3'd5,
   parameter logic [2:0] CLEAR_COLOUR = 3'd7
) (
   input  logic       iClock,
   input  logic       iResetn,
   input  logic       start,
   input  logic [3:0] level,
   input  logic [3:0] seq_rd_addr,
   output logic [1:0] seq_rd_key,
   output logic [7:0] oX,
   output logic [6:0] oY,
   output logic [2:0] oColour,
   output logic       oPlot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GEN   = 3'd1,
      S_DRAW  = 3'd2,
      S_HOLD  = 3'd3,
      S_ERASE = 3'd4,
      S_GAP   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [24:0] ON_LAST  = 25'(ON_CYCLES - 1);
   localparam logic [24:0] OFF_LAST = 25'(OFF_CYCLES - 1);
   localparam logic [4:0]  BOX_LAST = 5'd23;

   state_t      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [3:0]  lvl_q, lvl_d;
   logic [3:0]  idx_q, idx_d;
   logic [4:0]  xoff_q, xoff_d;
   logic [4:0]  yoff_q, yoff_d;
   logic [24:0] wait_q, wait_d;
   logic [7:0]  ox_q, ox_d;
   logic [6:0]  oy_q, oy_d;
   logic [2:0]  colour_q, colour_d;
   logic        plot_q, plot_d;
   logic        mem_we;
   logic [1:0]  mem_q [16];
   logic [1:0]  cur_key;
   logic [7:0]  box_x;
   logic [6:0]  box_y;

   assign cur_key = mem_q[idx_q];

   always_comb begin
      box_x = 8'd38;
      box_y = 7'd54;
      case (cur_key)
         2'd0: begin box_x = 8'd38; box_y = 7'd54; end
         2'd1: begin box_x = 8'd68; box_y = 7'd84; end
         2'd2: begin box_x = 8'd68; box_y = 7'd54; end
         2'd3: begin box_x = 8'd98; box_y = 7'd54; end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      lvl_d    = lvl_q;
      idx_d    = idx_q;
      xoff_d   = xoff_q;
      yoff_d   = yoff_q;
      wait_d   = wait_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      mem_we   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               lvl_d   = level;
               idx_d   = 4'd0;
               state_d = (level == 4'd0) ? S_DONE : S_GEN;
            end
         end
         S_GEN: begin
            mem_we = 1'b1;
            if (idx_q == lvl_q - 4'd1) begin
               idx_d   = 4'd0;
               xoff_d  = 5'd0;
               yoff_d  = 5'd0;
               state_d = S_DRAW;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_DRAW, S_ERASE: begin
            // Outputs are registered, so each strobe lands one cycle after its pixel is chosen.
            plot_d   = 1'b1;
            ox_d     = box_x + {3'b000, xoff_q};
            oy_d     = box_y + {2'b00, yoff_q};
            colour_d = (state_q == S_DRAW) ? FLASH_COLOUR : CLEAR_COLOUR;
            if (xoff_q == BOX_LAST) begin
               xoff_d = 5'd0;
               if (yoff_q == BOX_LAST) begin
                  yoff_d  = 5'd0;
                  wait_d  = 25'd0;
                  state_d = (state_q == S_DRAW) ? S_HOLD : S_GAP;
               end else begin
                  yoff_d = yoff_q + 5'd1;
               end
            end else begin
               xoff_d = xoff_q + 5'd1;
            end
         end
         S_HOLD: begin
            if (wait_q == ON_LAST) begin
               wait_d  = 25'd0;
               state_d = S_ERASE;
            end else begin
               wait_d = wait_q + 25'd1;
            end
         end
         S_GAP: begin
            if (wait_q == OFF_LAST) begin
               wait_d = 25'd0;
               if (idx_q == lvl_q - 4'd1) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_DRAW;
               end
            end else begin
               wait_d = wait_q + 25'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         state_q  <= S_IDLE;
         lfsr_q   <= LFSR_SEED;
         lvl_q    <= 4'd0;
         idx_q    <= 4'd0;
         xoff_q   <= 5'd0;
         yoff_q   <= 5'd0;
         wait_q   <= 25'd0;
         ox_q     <= 8'd0;
         oy_q     <= 7'd0;
         colour_q <= 3'd0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         lvl_q    <= lvl_d;
         idx_q    <= idx_d;
         xoff_q   <= xoff_d;
         yoff_q   <= yoff_d;
         wait_q   <= wait_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
      end
   end

   // Sequence storage survives reset on purpose.
   always_ff @(posedge iClock) begin
      if (mem_we) begin
         mem_q[idx_q] <= lfsr_q[1:0];
      end
   end

   assign seq_rd_key = mem_q[seq_rd_addr];
   assign oX         = ox_q;
   assign oY         = oy_q;
   assign oColour    = colour_q;
   assign oPlot      = plot_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pattern_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_display
// Purpose  : Randomised self-checking bench for pattern_display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_display;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int ELEM_CYCLES = 576 + ON + 576 + OFF;

   logic       iClock = 1'b0;
   logic       iResetn = 1'b0;
   logic       start = 1'b0;
   logic [3:0] level = 4'd0;
   logic [3:0] seq_rd_addr = 4'd0;
   logic [1:0] seq_rd_key;
   logic [7:0] oX;
   logic [6:0] oY;
   logic [2:0] oColour;
   logic       oPlot;
   logic       busy;
   logic       done;

   always #5 iClock = ~iClock;

   pattern_display #(
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF)
   ) dut (
      .iClock      (iClock),
      .iResetn     (iResetn),
      .start       (start),
      .level       (level),
      .seq_rd_addr (seq_rd_addr),
      .seq_rd_key  (seq_rd_key),
      .oX          (oX),
      .oY          (oY),
      .oColour     (oColour),
      .oPlot       (oPlot),
      .busy        (busy),
      .done        (done)
   );

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   int   errors = 0;
   int   checks = 0;
   pix_t pix_q[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   busy_cnt = 0;
   int   bursts = 0;
   logic prev_plot = 1'b0;
   logic [7:0] model_lfsr = 8'hA5;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], ^(l & 8'hB8)};
   endfunction

   function automatic int origin_x(input logic [1:0] k);
      case (k)
         2'd0:    return 38;
         2'd1:    return 68;
         2'd2:    return 68;
         default: return 98;
      endcase
   endfunction

   function automatic int origin_y(input logic [1:0] k);
      return (k == 2'd1) ? 84 : 54;
   endfunction

   always @(posedge iClock) begin
      cyc        <= cyc + 1;
      model_lfsr <= !iResetn ? 8'hA5 : lfsr_step(model_lfsr);
   end

   always @(negedge iClock) begin
      if (oPlot) begin
         pix_q.push_back({oX, oY, oColour});
         if (!prev_plot) bursts++;
      end
      prev_plot = oPlot;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One full round; expected keys come from stepping the LFSR once per GEN cycle.
   task automatic run_round(input int lvl, input bit disturb);
      logic [7:0] l;
      logic [1:0] keys [16];
      int         start_cyc;
      int         n;
      int         bad;
      int         q;
      pix_t       got;
      pix_t       want;

      @(negedge iClock);
      level = 4'(lvl);
      start = 1'b1;
      l = model_lfsr;
      for (int i = 0; i < lvl; i++) begin
         l = lfsr_step(l);
         keys[i] = l[1:0];
      end
      pix_q.delete();
      done_cnt  = 0;
      busy_cnt  = 0;
      bursts    = 0;
      start_cyc = cyc;
      @(negedge iClock);
      start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge iClock);
         n++;
         start = (disturb && pix_q.size() == 100) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      repeat (3) @(negedge iClock);

      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("done_latency", 32'(done_cyc - start_cyc), 32'(1 + lvl + ELEM_CYCLES * lvl));
      chk("busy_cycles", 32'(busy_cnt), 32'(1 + lvl + ELEM_CYCLES * lvl));
      chk("busy_after", 32'(busy), 32'd0);
      chk("strobes", 32'(pix_q.size()), 32'(1152 * lvl));
      chk("bursts", 32'(bursts), 32'(2 * lvl));
      for (int e = 0; e < lvl; e++) begin
         bad = 0;
         for (int p = 0; p < 1152; p++) begin
            q      = p % 576;
            want.x = 8'(origin_x(keys[e]) + q % 24);
            want.y = 7'(origin_y(keys[e]) + q / 24);
            want.c = (p < 576) ? 3'd5 : 3'd7;
            if (e * 1152 + p < pix_q.size()) begin
               got = pix_q[e * 1152 + p];
               if (got !== want) bad++;
            end else begin
               bad++;
            end
         end
         chk($sformatf("box%0d_key%0d", e, keys[e]), 32'(bad), 32'd0);
      end
      for (int i = 0; i < lvl; i++) begin
         seq_rd_addr = 4'(i);
         #1;
         chk($sformatf("seq_key%0d", i), 32'(seq_rd_key), 32'(keys[i]));
      end
   endtask

   initial begin
      int n;

      repeat (3) @(negedge iClock);
      chk("rst_oX", 32'(oX), 32'd0);
      chk("rst_oY", 32'(oY), 32'd0);
      chk("rst_colour", 32'(oColour), 32'd0);
      chk("rst_plot", 32'(oPlot), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      iResetn = 1'b1;
      repeat ($urandom_range(0, 7)) @(negedge iClock);

      run_round(1, 1'b0);
      run_round(3, 1'b0);
      run_round(0, 1'b0);
      run_round($urandom_range(1, 2), 1'b1);

      // Reset while the second box is half drawn.
      @(negedge iClock);
      level = 4'd2;
      start = 1'b1;
      pix_q.delete();
      done_cnt = 0;
      @(negedge iClock);
      start = 1'b0;
      n = 0;
      while (pix_q.size() < 1152 + 300 && n < 20000) begin
         @(negedge iClock);
         n++;
      end
      chk("reached_px300", 32'(pix_q.size() >= 1452), 32'd1);
      iResetn = 1'b0;
      @(negedge iClock);
      chk("midrst_plot", 32'(oPlot), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_oX", 32'(oX), 32'd0);
      iResetn = 1'b1;
      repeat (20) @(negedge iClock);
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
      run_round(1, 1'b0);

      repeat (3) begin
         repeat ($urandom_range(0, 9)) @(negedge iClock);
         run_round($urandom_range(1, 3), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
